alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 Derived localparam CNT_W = $clog2(WIDTH)+1, iteration counter width; not overridable.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 available  input  1  operation request; held high by requester until result consumed.
REQ-006 op  input  5  operation select; sampled only when request accepted.
REQ-007 in_a  input  WIDTH  operand A (multiplicand / dividend).
REQ-008 in_b  input  WIDTH  operand B (multiplier / divisor).
REQ-009 out  output  WIDTH  registered result.
REQ-010 busy  output  1  operation in progress.
REQ-011 fault  output  1  invalid op for current request.

Function
REQ-012 Op map: 00000 MUL (low half), 00001 MULH (s x s, high), 00010 MULHSU (s x u, high), 00011 MULHU (u x u, high), 00100 DIV, 00101 DIVU, 00110 REM, 00111 REMU; all other codes invalid.
REQ-013 States: IDLE, ITER, FIXUP, DONE; no other encodings reachable.
REQ-014 IDLE, available=1, valid op: latch op, sign flags, magnitudes of in_a/in_b, clear accumulator, counter<=WIDTH-1, busy<=1, state<=ITER.
REQ-015 IDLE, available=1, invalid op: fault<=1, busy stays 0, out unchanged, state<=DONE.
REQ-016 IDLE, available=0: busy<=0, fault<=0, all else held.
REQ-017 ITER: one radix-2 step per cycle (shift-add multiply, restoring divide on 2*WIDTH-bit partial); counter decrements; at counter=0 state<=FIXUP; exactly WIDTH cycles in ITER.
REQ-018 FIXUP: apply sign correction (negate product if operand signs differ for signed forms; quotient sign = sign_a^sign_b, remainder sign = sign_a), write out, busy<=0, state<=DONE.
REQ-019 Latency: request sampled at edge 0; busy high from edge 0; out valid and busy low after edge WIDTH+1; fixed for all valid ops including special cases.
REQ-020 DONE: out and fault held; state<=IDLE when available=0; no new request accepted while in DONE.
REQ-021 Operands, op changes during ITER/FIXUP/DONE ignored.
REQ-022 Divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = in_a; fault stays 0.
REQ-023 Signed overflow (in_a = 1<<(WIDTH-1), in_b = all ones, DIV/REM): quotient = in_a, remainder = 0; fault stays 0.
REQ-024 Magnitude of most-negative value handled as unsigned WIDTH-bit 1<<(WIDTH-1), no overflow in datapath.
REQ-025 MULH* high half = bits [2*WIDTH-1:WIDTH] of exact 2*WIDTH-bit product; MUL = bits [WIDTH-1:0].

Reset
REQ-026 reset=0 immediately (no clock) forces state=IDLE, busy=0, fault=0, out=0, counter=0.
REQ-027 Reset mid-operation aborts; after release, first request accepted in IDLE as normal with no residue of aborted op.
REQ-028 Request with available=1 at reset release accepted on first rising edge after release.

Verification
REQ-029 WIDTH=32, MUL, a=0xFFFFFFFF, b=0x00000002 -> busy high 33 cycles, out=0xFFFFFFFE, fault=0.
REQ-030 WIDTH=32, MULH a=0x80000000 b=0x80000000 -> out=0x40000000; MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> out=0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
REQ-031 WIDTH=32, DIV a=-7 b=2 -> out=0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU a=7 b=0 -> 0xFFFFFFFF; REMU a=7 b=0 -> 7.
REQ-032 WIDTH=32, DIV a=0x80000000 b=0xFFFFFFFF -> out=0x80000000; REM same -> 0, fault=0.
REQ-033 op=01000 with available=1 -> fault=1 after one edge, busy never high, out unchanged; fault clears one edge after available drops.
REQ-034 WIDTH=8, DIVU a=0xC8 b=0x07 started, reset pulsed low at ITER cycle 4 -> busy=0 immediately; next MUL a=0x0F b=0x11 -> out=0xFF after 9 edges.

Source files
------------

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide unit. Runs a fixed WIDTH-cycle loop on operand
// magnitudes, then applies the sign correction once in a final FIXUP cycle.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             available,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             fault
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIXUP, S_DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic             r_sa, r_sb, r_bzero;
  logic [WIDTH-1:0] r_ma, r_mb;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_busy, r_fault;

  // request decode: signedness per operand, magnitudes (most-negative maps to 1<<(WIDTH-1))
  logic             w_valid, w_sa_in, w_sb_in;
  logic [WIDTH-1:0] w_ma_in, w_mb_in;

  assign w_valid = (op[4:3] == 2'b00);
  assign w_sa_in = in_a[WIDTH-1] & ((op[2:0] == 3'd1) | (op[2:0] == 3'd2) |
                                    (op[2:0] == 3'd4) | (op[2:0] == 3'd6));
  assign w_sb_in = in_b[WIDTH-1] & ((op[2:0] == 3'd1) | (op[2:0] == 3'd4) |
                                    (op[2:0] == 3'd6));
  assign w_ma_in = w_sa_in ? ('0 - in_a) : in_a;
  assign w_mb_in = w_sb_in ? ('0 - in_b) : in_b;

  // multiply step: {hi,lo} holds partial product over the shifting multiplier
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_msum;

  assign w_addend = r_lo[0] ? r_ma : '0;
  assign w_msum   = {1'b0, r_hi} + {1'b0, w_addend};

  // restoring divide step: hi is partial remainder, lo shifts dividend out / quotient in
  logic [WIDTH:0]   w_shr;
  logic             w_ge;
  logic [WIDTH-1:0] w_dsub;

  assign w_shr  = {r_hi, r_lo[WIDTH-1]};
  assign w_ge   = (w_shr >= {1'b0, r_mb});
  assign w_dsub = w_shr[WIDTH-1:0] - r_mb;

  // sign correction
  logic               w_neg;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0]   w_quo, w_rem, w_res;

  assign w_neg    = r_sa ^ r_sb;
  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = w_neg ? ('0 - w_prod) : w_prod;
  assign w_quo    = r_bzero ? '1 : (w_neg ? ('0 - r_lo) : r_lo);
  assign w_rem    = r_sa ? ('0 - r_hi) : r_hi;

  always_comb begin
    w_res = '0;
    case (r_op)
      3'd0:             w_res = w_prod_s[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: w_res = w_prod_s[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:       w_res = w_quo;
      default:          w_res = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_bzero <= 1'b0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (available) begin
            if (w_valid) begin
              r_op    <= op[2:0];
              r_sa    <= w_sa_in;
              r_sb    <= w_sb_in;
              r_bzero <= (in_b == '0);
              r_ma    <= w_ma_in;
              r_mb    <= w_mb_in;
              r_hi    <= '0;
              r_lo    <= op[2] ? w_ma_in : w_mb_in;
              r_cnt   <= CNT_W'(WIDTH - 1);
              r_busy  <= 1'b1;
              r_fault <= 1'b0;
              r_state <= S_ITER;
            end else begin
              r_fault <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
          end
        end
        S_ITER: begin
          if (r_op[2]) begin
            r_hi <= w_ge ? w_dsub : w_shr[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_ge};
          end else begin
            r_hi <= w_msum[WIDTH:1];
            r_lo <= {w_msum[0], r_lo[WIDTH-1:1]};
          end
          if (r_cnt == '0) begin
            r_state <= S_FIXUP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_FIXUP: begin
          r_out   <= w_res;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // held until the requester releases; no re-accept from here
          if (!available) begin
            r_fault <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out   = r_out;
  assign busy  = r_busy;
  assign fault = r_fault;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed corner vectors, randomized ops against
// a plain-arithmetic model, invalid ops, DONE hold, and async reset abort at WIDTH=8.
module tb_alu_muldiv;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32 = 1'b1, av32 = 1'b0, busy32, flt32;
  logic [4:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0, out32;
  logic        rst8 = 1'b1, av8 = 1'b0, busy8, flt8;
  logic [4:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, out8;

  int n_tests = 0;
  int n_fail  = 0;

  alu_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst32), .available(av32), .op(op32),
    .in_a(a32), .in_b(b32), .out(out32), .busy(busy32), .fault(flt32));

  alu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .available(av8), .op(op8),
    .in_a(a8), .in_b(b8), .out(out8), .busy(busy8), .fault(flt8));

  function automatic logic [31:0] model32(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    logic [63:0]     p;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  // issue one request on dut32, scramble inputs while busy, return result and busy length
  task automatic run32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int bcyc, output logic flt);
    @(negedge clk);
    op32 = op; a32 = a; b32 = b; av32 = 1'b1;
    bcyc = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) begin
      if (!busy32) break;
      bcyc++;
      op32 = 5'($urandom); a32 = $urandom; b32 = $urandom;
      @(posedge clk); #1;
    end
    res = out32;
    flt = flt32;
    @(negedge clk); av32 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #1; rst32 = 1'b0; rst8 = 1'b0;
    #1;
    n_tests++;
    if (out32 !== 32'h0 || busy32 !== 1'b0 || flt32 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset32: out=%h busy=%b fault=%b, want 0/0/0", out32, busy32, flt32);
    end
    n_tests++;
    if (out8 !== 8'h0 || busy8 !== 1'b0 || flt8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset8: out=%h busy=%b fault=%b, want 0/0/0", out8, busy8, flt8);
    end
    @(negedge clk); rst32 = 1'b1; rst8 = 1'b1;
  endtask

  task automatic test_vectors;
    logic [4:0]  vop[12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd5, 5'd7, 5'd4, 5'd6, 5'd4, 5'd6};
    logic [31:0] va[12]  = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7,
                             32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] vb[12]  = '{32'd2, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd2, 32'd2, 32'd0, 32'd0,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] vx[12]  = '{32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE,
                             32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7,
                             32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9};
    logic [31:0] res;
    int          bc;
    logic        flt;
    for (int i = 0; i < 12; i++) begin
      run32(vop[i], va[i], vb[i], res, bc, flt);
      n_tests++;
      if (res !== vx[i] || bc != 33 || flt !== 1'b0) begin
        n_fail++;
        $display("FAIL vector%0d op=%0d: out=%h busy_cycles=%0d fault=%b, want %h/33/0",
                 i, vop[i], res, bc, flt, vx[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [4:0]  op;
    logic [31:0] a, b, res, exp;
    int          bc;
    logic        flt;
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(0, 15)); end
        default: ;
      endcase
      exp = model32(op[2:0], a, b);
      run32(op, a, b, res, bc, flt);
      n_tests++;
      if (res !== exp || bc != 33 || flt !== 1'b0) begin
        n_fail++;
        $display("FAIL random%0d op=%0d a=%h b=%h: out=%h busy_cycles=%0d fault=%b, want %h/33/0",
                 i, op, a, b, res, bc, flt, exp);
      end
    end
  endtask

  task automatic test_invalid;
    logic [31:0] res;
    int          bc;
    logic        flt, saw_busy;
    logic [4:0]  codes[2];
    codes[0] = 5'b01000;
    codes[1] = 5'($urandom_range(9, 31));
    run32(5'd0, 32'd6, 32'd7, res, bc, flt);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      op32 = codes[k]; a32 = $urandom; b32 = $urandom; av32 = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (flt32 !== 1'b1 || busy32 !== 1'b0 || out32 !== 32'd42) begin
        n_fail++;
        $display("FAIL invalid_op%0d: fault=%b busy=%b out=%h, want 1/0/0000002a",
                 codes[k], flt32, busy32, out32);
      end
      saw_busy = 1'b0;
      repeat (4) begin
        @(posedge clk); #1;
        if (busy32 !== 1'b0 || flt32 !== 1'b1) saw_busy = 1'b1;
      end
      n_tests++;
      if (saw_busy) begin
        n_fail++;
        $display("FAIL invalid_hold: busy/fault changed while held, got busy=%b fault=%b", busy32, flt32);
      end
      @(negedge clk); av32 = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (flt32 !== 1'b0) begin
        n_fail++;
        $display("FAIL invalid_clear: fault=%b one edge after drop, want 0", flt32);
      end
    end
  endtask

  task automatic test_done_hold;
    logic bad = 1'b0;
    @(negedge clk);
    op32 = 5'd0; a32 = 32'd3; b32 = 32'd5; av32 = 1'b1;
    repeat (34) @(posedge clk);
    #1;
    repeat (6) begin
      op32 = 5'd0; a32 = $urandom; b32 = $urandom;
      @(posedge clk); #1;
      if (busy32 !== 1'b0 || out32 !== 32'd15) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL done_hold: busy=%b out=%h, want 0/0000000f held", busy32, out32);
    end
    @(negedge clk); av32 = 1'b0;
    @(posedge clk); @(posedge clk);
  endtask

  task automatic test_reset_abort;
    int bc = 0;
    @(negedge clk);
    op8 = 5'd5; a8 = 8'hC8; b8 = 8'h07; av8 = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2; rst8 = 1'b0;
    #1;
    n_tests++;
    if (busy8 !== 1'b0 || out8 !== 8'h0 || flt8 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: busy=%b out=%h fault=%b, want 0/00/0", busy8, out8, flt8);
    end
    @(negedge clk);
    op8 = 5'd0; a8 = 8'h0F; b8 = 8'h11; av8 = 1'b1;
    @(negedge clk); rst8 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      if (!busy8) break;
      bc++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (out8 !== 8'hFF || bc != 9 || flt8 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next_mul: out=%h busy_cycles=%0d fault=%b, want ff/9/0", out8, bc, flt8);
    end
    @(negedge clk); av8 = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_invalid;
    test_done_hold;
    test_random;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
